// File: rtl/iot_event_pkg.sv
// Shared types and constants for the device-activity event encoder.
// Optional build macro IOT_SHADOW_COUNT_EN enables the local shadow counter.
package iot_event_pkg;

  localparam int N_DEV_DEF = 8;
  localparam int CNT_W     = 8;

  // dev_id width for a given device count; at least one bit
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = id_width(N_DEV_DEF);

  typedef struct packed {
    logic                on_off;
    logic [ID_W_DEF-1:0] id;
  } iot_event_t;

endpackage

// File: rtl/iot_event_encoder_if.sv
// Event bus between the activity encoder (master) and the active-device monitor (slave).
// With IOT_SHADOW_COUNT_EN defined the bus also carries shadow_count.
interface iot_event_if #(
  parameter int N_DEV = iot_event_pkg::N_DEV_DEF,
  parameter int ID_W  = iot_event_pkg::id_width(N_DEV)
) ();

  logic [N_DEV-1:0] dev_active;
  logic             change;
  logic             on_off;
  logic [ID_W-1:0]  dev_id;
  logic             pending;
`ifdef IOT_SHADOW_COUNT_EN
  logic [iot_event_pkg::CNT_W-1:0] shadow_count;

  modport master (input dev_active, output change, on_off, dev_id, pending, shadow_count);
  modport slave  (output dev_active, input change, on_off, dev_id, pending, shadow_count);
`else
  modport master (input dev_active, output change, on_off, dev_id, pending);
  modport slave  (output dev_active, input change, on_off, dev_id, pending);
`endif

endinterface

// File: rtl/iot_event_encoder_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The owner of ptr advances it after each grant.
module rr_arbiter #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_DEV-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_idx
);

  // Scan N_DEV positions starting at ptr, keep the first hit
  always_comb begin
    int              sum;
    logic [ID_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = 0;
    idx         = '0;
    for (int k = 0; k < N_DEV; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N_DEV) sum = sum - N_DEV;
      idx = ID_W'(sum);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/iot_event_encoder.sv
// Device-activity event encoder: detects per-device level transitions, queues them,
// and serialises them round-robin into at most one change strobe per clock.
// Optional macro IOT_SHADOW_COUNT_EN adds a local running on-minus-off count.
module iot_event_encoder
  import iot_event_pkg::*;
#(
  parameter int N_DEV = N_DEV_DEF,
  parameter int ID_W  = id_width(N_DEV)
) (
  input  logic        clk,
  input  logic        rst,
  iot_event_if.master ev
);

  logic [N_DEV-1:0] dev_q;
  logic [N_DEV-1:0] pend_q, pend_d;
  logic [N_DEV-1:0] pdir_q, pdir_d;
  logic [N_DEV-1:0] edg_w;
  logic [N_DEV-1:0] gnt_oh_w;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  gnt_idx_w;
  logic             gnt_vld_w;

  logic             change_q;
  logic             on_off_q;
  logic [ID_W-1:0]  dev_id_q;
  logic             pending_q;

  assign edg_w    = ev.dev_active ^ dev_q;
  assign gnt_oh_w = gnt_vld_w ? (N_DEV'(1) << gnt_idx_w) : '0;

  rr_arbiter #(
    .N_DEV (N_DEV),
    .ID_W  (ID_W)
  ) u_arb (
    .req         (pend_q),
    .ptr         (ptr_q),
    .grant_valid (gnt_vld_w),
    .grant_idx   (gnt_idx_w)
  );

  // Per-device queue update: new edges queue, a second edge on a waiting device cancels
  always_comb begin
    pend_d = pend_q;
    pdir_d = pdir_q;
    for (int i = 0; i < N_DEV; i++) begin
      if (gnt_oh_w[i]) pend_d[i] = 1'b0;
      if (edg_w[i]) begin
        if (!pend_q[i] || gnt_oh_w[i]) begin
          pend_d[i] = 1'b1;
          pdir_d[i] = ev.dev_active[i];
        end else begin
          pend_d[i] = 1'b0;
        end
      end
    end
  end

  // Pointer moves just past the granted device so every requester is reached within N_DEV grants
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_w) begin
      ptr_d = (gnt_idx_w == ID_W'(N_DEV - 1)) ? '0 : gnt_idx_w + ID_W'(1);
    end
  end

  // Control state and registered event outputs; on_off/dev_id hold between grants
  always_ff @(posedge clk) begin
    if (rst) begin
      dev_q     <= '0;
      pend_q    <= '0;
      ptr_q     <= '0;
      change_q  <= 1'b0;
      on_off_q  <= 1'b0;
      dev_id_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      dev_q     <= ev.dev_active;
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      change_q  <= gnt_vld_w;
      pending_q <= |pend_d;
      if (gnt_vld_w) begin
        on_off_q <= pdir_q[gnt_idx_w];
        dev_id_q <= gnt_idx_w;
      end
    end
  end

  // Queued direction is only meaningful while the matching pend bit is set
  always_ff @(posedge clk) begin
    pdir_q <= pdir_d;
  end

  assign ev.change  = change_q;
  assign ev.on_off  = on_off_q;
  assign ev.dev_id  = dev_id_q;
  assign ev.pending = pending_q;

`ifdef IOT_SHADOW_COUNT_EN
  logic [CNT_W-1:0] shadow_q;

  // Mirror of the downstream monitor count, updated alongside each emitted event
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (gnt_vld_w) begin
      shadow_q <= shadow_q + (pdir_q[gnt_idx_w] ? CNT_W'(1) : {CNT_W{1'b1}});
    end
  end

  assign ev.shadow_count = shadow_q;
`endif

endmodule

// File: tb/tb_iot_event_encoder.sv
// Directed bench for iot_event_encoder: a per-cycle vector table plus hand-written
// sequences for burst, cancellation, mid-run reset and a random toggle soak.
module tb_iot_event_encoder;
  import iot_event_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  iot_event_if #(.N_DEV(8)) ev_if ();

  iot_event_encoder #(.N_DEV(8)) dut (
    .clk (clk),
    .rst (rst),
    .ev  (ev_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] da;
    logic       chg;
    logic       oo;
    logic [2:0] id;
    logic       pend;
    logic [7:0] sh;
  } vec_t;

  vec_t       tbl [12];
  logic [7:0] tb_level;
  int         age [8];
  int         max_age;
  int         ids_c [7];
  iot_event_t exp_ev;
  int         seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ev_if.dev_active = 8'h00;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_shadow(input string nm, input logic [7:0] exp);
`ifdef IOT_SHADOW_COUNT_EN
    chk(nm, ev_if.shadow_count, exp);
`endif
  endtask

  // Emitted events for one device must alternate; also track how long a level change waits
  task automatic observe(input logic [7:0] da_now);
    if (ev_if.change) begin
      chk("alternation", ev_if.on_off, !tb_level[ev_if.dev_id]);
      tb_level[ev_if.dev_id] = ev_if.on_off;
    end
    for (int i = 0; i < 8; i++) begin
      if (ev_if.change && ev_if.dev_id == 3'(i)) age[i] = 0;
      else if (tb_level[i] != da_now[i])        age[i] = age[i] + 1;
      else                                       age[i] = 0;
      if (age[i] > max_age) max_age = age[i];
    end
  endtask

  initial begin
    // da, change, on_off, dev_id, pending, shadow after the step
    tbl[0]  = '{8'h05, 1'b0, 1'b0, 3'd0, 1'b1, 8'd0};
    tbl[1]  = '{8'h05, 1'b1, 1'b1, 3'd0, 1'b1, 8'd1};
    tbl[2]  = '{8'h05, 1'b1, 1'b1, 3'd2, 1'b0, 8'd2};
    tbl[3]  = '{8'h05, 1'b0, 1'b1, 3'd2, 1'b0, 8'd2};
    tbl[4]  = '{8'h0D, 1'b0, 1'b1, 3'd2, 1'b1, 8'd2};
    tbl[5]  = '{8'h0D, 1'b1, 1'b1, 3'd3, 1'b0, 8'd3};
    tbl[6]  = '{8'h0D, 1'b0, 1'b1, 3'd3, 1'b0, 8'd3};
    tbl[7]  = '{8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 8'd3};
    tbl[8]  = '{8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 8'd2};
    tbl[9]  = '{8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'd1};
    tbl[10] = '{8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 8'd0};
    tbl[11] = '{8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 8'd0};
    ids_c   = '{0, 1, 2, 3, 4, 6, 7};

    // Reset state while devices 0 and 2 are already active
    rst = 1'b1;
    ev_if.dev_active = 8'h05;
    step();
    step();
    chk("rst_change",  ev_if.change,  1'b0);
    chk("rst_on_off",  ev_if.on_off,  1'b0);
    chk("rst_dev_id",  ev_if.dev_id,  3'd0);
    chk("rst_pending", ev_if.pending, 1'b0);
    chk_shadow("rst_shadow", 8'd0);
    rst = 1'b0;

    // Table: reset release, single turn-on, wrapped round-robin turn-offs
    for (int i = 0; i < 12; i++) begin
      ev_if.dev_active = tbl[i].da;
      step();
      chk($sformatf("tbl%0d_change", i),  ev_if.change,  tbl[i].chg);
      chk($sformatf("tbl%0d_on_off", i),  ev_if.on_off,  tbl[i].oo);
      chk($sformatf("tbl%0d_dev_id", i),  ev_if.dev_id,  tbl[i].id);
      chk($sformatf("tbl%0d_pending", i), ev_if.pending, tbl[i].pend);
      chk_shadow($sformatf("tbl%0d_shadow", i), tbl[i].sh);
    end

    // All devices on at once, then all off
    do_reset();
    ev_if.dev_active = 8'hFF;
    step();
    chk("burst_on_wait", ev_if.change, 1'b0);
    chk("burst_on_pending", ev_if.pending, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      exp_ev = '{on_off: 1'b1, id: 3'(i)};
      chk($sformatf("burst_on%0d_change", i), ev_if.change, 1'b1);
      chk($sformatf("burst_on%0d_event", i), {ev_if.on_off, ev_if.dev_id}, exp_ev);
    end
    step();
    chk("burst_on_done", {ev_if.change, ev_if.pending}, 2'b00);
    chk_shadow("burst_on_shadow", 8'd8);
    ev_if.dev_active = 8'h00;
    step();
    chk("burst_off_pending", ev_if.pending, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      exp_ev = '{on_off: 1'b0, id: 3'(i)};
      chk($sformatf("burst_off%0d_change", i), ev_if.change, 1'b1);
      chk($sformatf("burst_off%0d_event", i), {ev_if.on_off, ev_if.dev_id}, exp_ev);
    end
    step();
    chk("burst_off_done", {ev_if.change, ev_if.pending}, 2'b00);
    chk_shadow("burst_off_shadow", 8'd0);

    // Device 5 pulses on for one cycle behind seven queued events: it must cancel
    do_reset();
    ev_if.dev_active = 8'hDF;
    step();
    chk("cancel_wait", ev_if.change, 1'b0);
    ev_if.dev_active = 8'hFF;
    step();
    ev_if.dev_active = 8'hDF;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step();
      chk($sformatf("cancel%0d_change", k), ev_if.change, 1'b1);
      chk($sformatf("cancel%0d_event", k), {ev_if.on_off, ev_if.dev_id}, {1'b1, 3'(ids_c[k])});
    end
    step();
    chk("cancel_done", {ev_if.change, ev_if.pending}, 2'b00);
    chk_shadow("cancel_shadow", 8'd7);

    // Reset while four events are queued discards them
    do_reset();
    ev_if.dev_active = 8'h0F;
    step();
    chk("midrst_queued", ev_if.pending, 1'b1);
    rst = 1'b1;
    ev_if.dev_active = 8'h00;
    step();
    rst = 1'b0;
    chk("midrst_change", ev_if.change, 1'b0);
    chk("midrst_pending", ev_if.pending, 1'b0);
    chk_shadow("midrst_shadow", 8'd0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ev_if.change) seen++;
    end
    chk("midrst_no_stale", seen, 0);

    // Random toggle soak followed by quiescence
    do_reset();
    tb_level = 8'h00;
    max_age  = 0;
    for (int i = 0; i < 8; i++) age[i] = 0;
    for (int n = 0; n < 300; n++) begin
      ev_if.dev_active = ev_if.dev_active ^ (8'h01 << $urandom_range(0, 7));
      step();
      observe(ev_if.dev_active);
    end
    for (int n = 0; n < 12; n++) begin
      step();
      observe(ev_if.dev_active);
    end
    chk("soak_pending", ev_if.pending, 1'b0);
    chk("soak_level", tb_level, ev_if.dev_active);
    chk("soak_latency_ok", (max_age <= 8), 1'b1);
    chk_shadow("soak_shadow", 8'($countones(ev_if.dev_active)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
